// File: rtl/ahb_refill_master_if.sv
// AHB-Lite bus bundle between a single master and its slave side.
// The master drives the request channel; the slave answers with hready/hresp/hrdata.
interface ahb_lite;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hport;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output haddr, hwrite, hsize, hburst, hport, htrans, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hport, htrans, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_refill_master.sv
// Instruction-cache line refill master: one miss at a time, fetched as a
// critical-word-first WRAP4 read burst, critical word forwarded early.
module ahb_refill_master #(
    parameter logic [3:0] HPORT_VAL = 4'b0010
) (
    input  logic          hclk,
    input  logic          hrstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          crit_valid,
    output logic [31:0]   crit_data,
    output logic          line_valid,
    output logic          line_err,
    output logic [31:0]   line_addr,
    output logic [127:0]  line_data,
    ahb_lite.master       bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_DONE, S_ERR} state_t;

    state_t        state, state_next;
    logic [27:0]   base;
    logic [1:0]    w0, beat, beat_idx, dbeat, widx;
    logic          capture;
    logic [127:0]  line_buf, line_merge;
    logic          unused_addr_bits;

    assign bus.hwrite    = 1'b0;
    assign bus.hsize     = 3'b010;
    assign bus.hburst    = HBURST_WRAP4;
    assign bus.hport     = HPORT_VAL;
    assign bus.hmastlock = 1'b0;
    assign bus.hwdata    = '0;
    assign unused_addr_bits = ^req_addr[1:0];

    // beat counts accepted address phases; the data phase in flight is one behind
    assign beat_idx = w0 + beat;
    assign dbeat    = beat - 2'd1;
    assign widx     = w0 + dbeat;
    assign capture  = (state == S_BURST || state == S_LAST) && bus.hready && !bus.hresp;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        bus.htrans = HTRANS_IDLE;
        bus.haddr  = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = S_ADDR;
            end
            S_ADDR: begin
                bus.htrans = HTRANS_NONSEQ;
                bus.haddr  = {base, beat_idx, 2'b00};
                if (bus.hready) state_next = S_BURST;
            end
            S_BURST: begin
                bus.htrans = HTRANS_SEQ;
                bus.haddr  = {base, beat_idx, 2'b00};
                if (bus.hresp && !bus.hready)      state_next = S_ERR;
                else if (bus.hready && beat == 2'd3) state_next = S_LAST;
            end
            S_LAST: begin
                if (bus.hresp && !bus.hready) state_next = S_ERR;
                else if (bus.hready)          state_next = S_DONE;
            end
            S_ERR: begin
                if (bus.hresp && bus.hready) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // merged view lets the final beat land in line_data on the same edge as DONE entry
    always_comb begin
        line_merge = line_buf;
        if (capture) line_merge[{widx, 5'd0} +: 32] = bus.hrdata;
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            base       <= '0;
            w0         <= '0;
            beat       <= '0;
            line_buf   <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            line_valid <= 1'b0;
            line_err   <= 1'b0;
            line_addr  <= '0;
            line_data  <= '0;
        end else begin
            crit_valid <= 1'b0;
            line_valid <= 1'b0;
            line_buf   <= line_merge;
            if (state == S_IDLE && req_valid) begin
                base <= req_addr[31:4];
                w0   <= req_addr[3:2];
                beat <= '0;
            end else if ((state == S_ADDR || state == S_BURST) && bus.hready) begin
                beat <= beat + 2'd1;
            end
            if (capture && dbeat == 2'd0) begin
                crit_valid <= 1'b1;
                crit_data  <= bus.hrdata;
            end
            if (state_next == S_DONE && state != S_DONE) begin
                line_valid <= 1'b1;
                line_err   <= (state == S_ERR);
                line_addr  <= {base, 4'b0000};
                line_data  <= line_merge;
            end
        end
    end
endmodule

// File: tb/tb_ahb_refill_master.sv
// Scoreboarded bench for ahb_refill_master: a reactive AHB slave with planned
// wait states and errors, expectations from a line-level reference model.
module tb_ahb_refill_master;
    logic          hclk = 1'b0;
    logic          hrstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic          line_valid;
    logic          line_err;
    logic [31:0]   line_addr;
    logic [127:0]  line_data;

    ahb_lite ahb();

    ahb_refill_master #(.HPORT_VAL(4'b0010)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .line_valid(line_valid), .line_err(line_err),
        .line_addr(line_addr), .line_data(line_data),
        .bus(ahb)
    );

    initial forever #5 hclk = ~hclk;

    int cyc = 0;
    initial forever begin @(posedge hclk); cyc++; end

    typedef struct packed { logic [3:0][1:0] w; logic [2:0] err; } plan_t;  // err=4: none
    typedef struct packed { logic [31:0] addr; logic [1:0] trans; } aexp_t;
    typedef struct packed { logic [31:0] data; logic [31:0] lat; } cexp_t;
    typedef struct packed { logic [127:0] data; logic [31:0] addr; logic err; logic [31:0] lat; } lexp_t;

    plan_t plan_q[$];
    aexp_t addr_q[$];
    cexp_t crit_q[$];
    lexp_t line_q[$];

    int checks = 0;
    int failures = 0;
    int line_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // Reference model: which beats the bus should carry, and what comes back when.
    task automatic model_push(input logic [31:0] addr, input plan_t p);
        logic [31:0] base;
        int          e, nb, lat;
        logic [1:0]  wi;
        aexp_t       a;
        cexp_t       c;
        lexp_t       l;
        base = {addr[31:4], 4'b0000};
        e    = int'(p.err);
        nb   = (e < 4) ? e + 1 : 4;
        for (int n = 0; n < nb; n++) begin
            wi      = addr[3:2] + 2'(n);
            a.addr  = base | {28'b0, wi, 2'b00};
            a.trans = (n == 0) ? 2'b10 : 2'b11;
            addr_q.push_back(a);
        end
        if (e != 0) begin
            c.data = mem({addr[31:2], 2'b00});
            c.lat  = 32'(3 + int'(p.w[0]));
            crit_q.push_back(c);
        end
        for (int k = 0; k < 4; k++) l.data[k*32 +: 32] = mem(base + 32'(4*k));
        if (e < 4) begin
            lat = 4 + e;
            for (int k = 0; k < e; k++) lat += int'(p.w[k]);
        end else begin
            lat = 6;
            for (int k = 0; k < 4; k++) lat += int'(p.w[k]);
        end
        l.addr = base;
        l.err  = (e < 4);
        l.lat  = 32'(lat);
        line_q.push_back(l);
    endtask

    // Reactive slave: samples the bus mid-cycle, updates responses just after the edge.
    logic        dp_active = 1'b0, dp_err = 1'b0, err_stage = 1'b0, s_ready;
    logic [31:0] dp_addr, s_addr;
    logic [1:0]  s_trans;
    int          wait_left = 0, beat_n = 0;
    plan_t       cur;
    initial begin
        ahb.hready = 1'b1; ahb.hresp = 1'b0; ahb.hrdata = '0;
        cur.w = '0; cur.err = 3'd4;
        forever begin
            @(negedge hclk);
            s_trans = ahb.htrans; s_addr = ahb.haddr; s_ready = ahb.hready;
            @(posedge hclk); #1;
            if (!hrstn) begin
                dp_active = 1'b0; ahb.hready = 1'b1; ahb.hresp = 1'b0; ahb.hrdata = '0;
                continue;
            end
            if (dp_active) begin
                if (s_ready)             dp_active = 1'b0;
                else if (dp_err)         err_stage = 1'b1;
                else if (wait_left > 0)  wait_left--;
            end
            if (s_trans != 2'b00 && s_ready) begin
                if (s_trans == 2'b10) begin
                    beat_n = 0;
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else begin cur.w = '0; cur.err = 3'd4; end
                end else beat_n++;
                dp_active = 1'b1;
                dp_addr   = s_addr;
                dp_err    = (int'(cur.err) == beat_n);
                err_stage = 1'b0;
                wait_left = (beat_n < 4) ? int'(cur.w[beat_n]) : 0;
            end
            if (!dp_active) begin
                ahb.hready = 1'b1; ahb.hresp = 1'b0; ahb.hrdata = $urandom;
            end else if (dp_err) begin
                ahb.hready = err_stage; ahb.hresp = 1'b1; ahb.hrdata = $urandom;
            end else if (wait_left > 0) begin
                ahb.hready = 1'b0; ahb.hresp = 1'b0; ahb.hrdata = $urandom;
            end else begin
                ahb.hready = 1'b1; ahb.hresp = 1'b0; ahb.hrdata = mem(dp_addr);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a beat, critical word or line.
    int          acc_cyc = 0;
    logic        prev_hold = 1'b0, prev_err1 = 1'b0, prev_lv = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [1:0]  prev_trans = '0;
    initial forever begin
        aexp_t a;
        cexp_t c;
        lexp_t l;
        @(negedge hclk);
        if (!hrstn) begin prev_hold = 1'b0; prev_err1 = 1'b0; prev_lv = 1'b0; continue; end
        if (prev_lv)   chk("req_ready_after_done", req_ready, 1'b1);
        if (prev_err1) chk("htrans_idle_after_error", ahb.htrans, 2'b00);
        if (prev_hold && ahb.htrans != 2'b00) begin
            chk("hold_haddr", ahb.haddr, prev_addr);
            chk("hold_htrans", ahb.htrans, prev_trans);
        end
        if (req_valid && req_ready) acc_cyc = cyc;
        if (ahb.htrans != 2'b00 && ahb.hready) begin
            if (addr_q.size() == 0) fail_evt("unexpected_beat");
            else begin
                a = addr_q.pop_front();
                chk("haddr", ahb.haddr, a.addr);
                chk("htrans", ahb.htrans, a.trans);
            end
        end
        if (crit_valid) begin
            if (crit_q.size() == 0) fail_evt("unexpected_crit_valid");
            else begin
                c = crit_q.pop_front();
                chk("crit_data", crit_data, c.data);
                chk("crit_latency", cyc - acc_cyc, c.lat);
            end
        end
        if (line_valid) begin
            line_cnt++;
            if (line_q.size() == 0) fail_evt("unexpected_line_valid");
            else begin
                l = line_q.pop_front();
                chk("line_err", line_err, l.err);
                chk("line_addr", line_addr, l.addr);
                if (!l.err) chk("line_data", line_data, l.data);
                chk("line_latency", cyc - acc_cyc, l.lat);
            end
        end
        prev_lv    = line_valid;
        prev_hold  = (ahb.htrans != 2'b00) && !ahb.hready;
        prev_addr  = ahb.haddr;
        prev_trans = ahb.htrans;
        prev_err1  = ahb.hresp && !ahb.hready;
    end

    task automatic wait_line(input int target);
        int n = 0;
        while (line_cnt < target && n < 100) begin @(negedge hclk); n++; end
        if (line_cnt < target) fail_evt("line_timeout");
    endtask

    task automatic refill(input logic [31:0] addr, input plan_t p, input bit wait_done);
        int target = line_cnt + 1;
        int n = 0;
        plan_q.push_back(p);
        model_push(addr, p);
        @(posedge hclk); #1;
        req_valid = 1'b1; req_addr = addr;
        do begin @(negedge hclk); n++; end while (!req_ready && n < 50);
        if (!req_ready) fail_evt("accept_timeout");
        @(posedge hclk); #1;
        req_valid = 1'b0; req_addr = $urandom;
        if (wait_done) begin
            wait_line(target);
            repeat (2) @(negedge hclk);
            chk("line_addr_hold", line_addr, {addr[31:4], 4'b0000});
            chk("line_err_hold", line_err, p.err < 3'd4);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_crit_valid"}, crit_valid, 1'b0);
        chk({tag, "_crit_data"}, crit_data, 32'h0);
        chk({tag, "_line_valid"}, line_valid, 1'b0);
        chk({tag, "_line_err"}, line_err, 1'b0);
        chk({tag, "_line_addr"}, line_addr, 32'h0);
        chk({tag, "_line_data"}, line_data, 128'h0);
        chk({tag, "_htrans"}, ahb.htrans, 2'b00);
        chk({tag, "_haddr"}, ahb.haddr, 32'h0);
    endtask

    initial begin
        plan_t p;
        int    acc, last, n, target;
        repeat (3) @(posedge hclk);
        #1;
        check_reset_outputs("reset");
        chk("hwrite", ahb.hwrite, 1'b0);
        chk("hsize", ahb.hsize, 3'b010);
        chk("hburst", ahb.hburst, 3'b010);
        chk("hport", ahb.hport, 4'b0010);
        chk("hmastlock", ahb.hmastlock, 1'b0);
        chk("hwdata", ahb.hwdata, 32'h0);
        #2 hrstn = 1'b1;

        p.w = '0; p.err = 3'd4;
        refill(32'h0000_1008, p, 1'b1);
        p.w[2] = 2'd2;
        refill(32'h0000_1008, p, 1'b1);
        p.w = '0; p.err = 3'd1;
        refill(32'h2000_0000, p, 1'b1);
        p.err = 3'd0;
        refill(32'h4567_89AC, p, 1'b1);

        // reset while the burst is on its last address beat, after the critical word
        p.err = 3'd4;
        refill(32'h3000_0014, p, 1'b0);
        repeat (3) @(posedge hclk);
        #3 hrstn = 1'b0;
        plan_q.delete(); addr_q.delete(); crit_q.delete(); line_q.delete();
        #1 check_reset_outputs("async_reset");
        @(posedge hclk);
        #3 hrstn = 1'b1;
        refill(32'h3000_0014, p, 1'b1);

        // req_valid held high: one accept per refill, seven cycles apart
        target = line_cnt + 3;
        for (int i = 0; i < 3; i++) begin
            plan_q.push_back(p);
            model_push(32'h0000_5A04, p);
        end
        @(posedge hclk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_5A04;
        acc = 0; last = 0; n = 0;
        while (acc < 3 && n < 100) begin
            @(negedge hclk); n++;
            if (req_ready) begin
                if (acc > 0) chk("accept_spacing", cyc - last, 7);
                last = cyc;
                acc++;
            end
        end
        if (acc < 3) fail_evt("held_accept_timeout");
        @(posedge hclk); #1;
        req_valid = 1'b0;
        wait_line(target);

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++)
                p.w[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            p.err = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
            refill($urandom, p, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge hclk);
        end

        repeat (5) @(negedge hclk);
        chk("addr_q_drained", addr_q.size(), 0);
        chk("crit_q_drained", crit_q.size(), 0);
        chk("line_q_drained", line_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
